multichannel_power_detector: RTL and testbench
==============================================

Name: multichannel_power_detector

Overview:
Time-multiplexed average power detector for complex baseband. It computes I²+Q² per sample and accumulates per channel over a runtime-selectable power-of-two window. At each window end it emits the average, a channel tag, a threshold flag and a per-channel peak-hold value. It sits after the DDC/channeliser, feeding AGC and squelch logic.

Parameters:
IQ_WIDTH, 16, signed width of I and Q samples
NUM_CH, 4, number of interleaved channels
CH_BITS, 2, channel index width (>= clog2(NUM_CH))
MAX_WIN_BITS, 12, largest window exponent (window = 2^win_bits samples)
OUT_WIDTH, 32, width of the average and peak outputs
ACC_WIDTH, 2*IQ_WIDTH+1+MAX_WIN_BITS, per-channel accumulator width (derived; never overflows)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_in  input  IQ_WIDTH  signed in-phase sample
q_in  input  IQ_WIDTH  signed quadrature sample
ch_in  input  CH_BITS  channel index of the current sample
sample_valid_in  input  1  sample qualifier
win_bits_cfg  input  4  window exponent, 0..MAX_WIN_BITS
threshold_cfg  input  OUT_WIDTH  unsigned detection threshold
clear_in  input  1  synchronous clear of all channel state
avg_power_out  output  OUT_WIDTH  window average
avg_ch_out  output  CH_BITS  channel of avg_power_out
avg_power_valid  output  1  one-cycle strobe qualifying all avg_* outputs
above_thresh_out  output  1  avg_power_out > threshold_cfg
peak_hold_out  output  OUT_WIDTH  max average of avg_ch_out since clear/reset

Behaviour:
- Reset (rst high, async): all outputs 0; all accumulators, counters, peaks and pipeline valids 0.
- Stage 1 (cycle N+1): register p = I²+Q², unsigned width 2*IQ_WIDTH+1, plus ch and valid.
- Stage 2 (N+2): acc[ch] += p; cnt[ch] += 1. Read-modify-write completes in one cycle, so back-to-back samples on the same channel need no stall.
- Window start: when cnt[ch]==0 and a sample arrives, win[ch] latches win_bits_cfg. Values above MAX_WIN_BITS clamp to MAX_WIN_BITS. A config change mid-window affects only the next window of that channel.
- Window end: the sample with cnt[ch]==2^win[ch]-1.
  - Stage 3 (N+3) registers avg = (acc[ch]+p) >> win[ch], truncating. If avg exceeds OUT_WIDTH it saturates to all-ones.
  - avg_power_valid pulses for 1 cycle with avg_ch_out=ch, above_thresh_out = (avg > threshold_cfg, strict), peak_hold_out = max(peak[ch], avg). peak[ch] updates to the same value.
  - acc[ch] and cnt[ch] reset to 0.
- Latency: last sample of a window to avg_power_valid = 3 cycles.
- win_bits=0: every sample produces an output equal to its power.
- Outputs hold their last values while avg_power_valid=0.
- ch_in >= NUM_CH: sample dropped; no state change.
- clear_in (synchronous, highest priority): zeros acc, cnt, peak and pipeline valids in the same edge. A sample coinciding with clear is dropped; an in-flight window end is suppressed.
- rst mid-window: partial accumulations discarded; counting restarts at 0 for all channels.
- At most one avg_power_valid per cycle, guaranteed by the single input stream.

Decomposition:
- Shared package power_det_pkg: IQ_WIDTH/OUT_WIDTH/MAX_WIN_BITS defaults, the ACC_WIDTH derivation function, and the saturating-shift function.
- One natural sub-module, iq_power_stage: the registered signed squarer/adder (stage 1), reusable by the AGC.
- Accumulator, counter, window and peak arrays stay in the top module.

Test Plan:
- Reset: hold rst 5 cycles with valid samples driven -> all outputs 0, no avg_power_valid; after release, first output needs a full window.
- Single channel: ch0, win_bits=2, I=3, Q=4 for 8 samples -> avg_power_out=25 and avg_ch_out=0, strobe 3 cycles after samples 4 and 8, exactly twice.
- Interleaved: win_bits=1, alternating ch0 (I=1,Q=0) and ch1 (I=-2,Q=-2) -> outputs ch0=1, ch1=8 with correct tags, back-to-back windows without loss.
- Full scale: I=Q=-32768, win_bits=12, 4096 samples on ch3 -> avg_power_out=0x80000000, no wrap.
- Threshold/peak: threshold_cfg=100, win_bits=0 on ch2, powers 25, 169 (I=5,Q=12), 25 -> above_thresh 0,1,0; peak_hold 25,169,169. Then clear_in, power 4 -> peak 4.
- Config/clear boundaries: win_bits 2→3 after 2 samples -> first output after 4 samples, next after 8 more. clear_in coincident with the 4th sample -> no strobe; rst mid-window -> partial sum discarded.

Source files
------------

// File: rtl/power_det_pkg.sv
// ----------------------------------------------------------------------------
// power_det_pkg
// Shared defaults and helpers for the multichannel power detector and any
// block that reuses its power stage (e.g. the AGC).
//   DEF_*          default widths for IQ samples, outputs and window exponent
//   acc_width()    accumulator width that cannot overflow for a full window
//   sat_shift()    right shift of an accumulated sum, saturated to out_width
// ----------------------------------------------------------------------------
package power_det_pkg;

    localparam int DEF_IQ_WIDTH     = 16;
    localparam int DEF_OUT_WIDTH    = 32;
    localparam int DEF_MAX_WIN_BITS = 12;

    // Width of the operand handed to sat_shift(); accumulators are
    // zero-extended to this before shifting.
    localparam int SAT_IN_WIDTH = 64;

    // I^2+Q^2 needs 2*iq_width+1 bits; summing 2^max_win_bits of them adds
    // max_win_bits more.
    function automatic int acc_width(input int iq_width, input int max_win_bits);
        return 2 * iq_width + 1 + max_win_bits;
    endfunction

    function automatic logic [SAT_IN_WIDTH-1:0] sat_shift(
        input logic [SAT_IN_WIDTH-1:0] value,
        input logic [3:0]              shift,
        input int                      out_width
    );
        logic [SAT_IN_WIDTH-1:0] shifted;
        logic [SAT_IN_WIDTH-1:0] limit;
        shifted = value >> shift;
        if (out_width >= SAT_IN_WIDTH)
            limit = '1;
        else
            limit = (SAT_IN_WIDTH'(1) << out_width) - SAT_IN_WIDTH'(1);
        return (shifted > limit) ? limit : shifted;
    endfunction

endpackage

// File: rtl/iq_power_stage.sv
// ----------------------------------------------------------------------------
// iq_power_stage
// Registered instantaneous power: power = I^2 + Q^2 (unsigned), with the
// channel tag and qualifier carried alongside.
//   clk, rst        clock, async active-high reset
//   clear           synchronous flush of the valid flag
//   i_in, q_in      signed samples
//   ch_in           channel tag of the sample
//   valid_in        sample qualifier
//   power           registered I^2+Q^2, 2*IQ_WIDTH+1 bits
//   ch, valid       registered tag and qualifier
// ----------------------------------------------------------------------------
module iq_power_stage
    import power_det_pkg::*;
#(
    parameter int IQ_WIDTH = DEF_IQ_WIDTH,
    parameter int CH_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [IQ_WIDTH-1:0]   i_in,
    input  logic [IQ_WIDTH-1:0]   q_in,
    input  logic [CH_BITS-1:0]    ch_in,
    input  logic                  valid_in,
    output logic [2*IQ_WIDTH:0]   power,
    output logic [CH_BITS-1:0]    ch,
    output logic                  valid
);

    logic signed [2*IQ_WIDTH-1:0] i_ext;
    logic signed [2*IQ_WIDTH-1:0] q_ext;
    logic signed [2*IQ_WIDTH-1:0] i_sq;
    logic signed [2*IQ_WIDTH-1:0] q_sq;
    logic        [2*IQ_WIDTH:0]   power_next;

    // Squares are computed at full product width; the largest one
    // ((-2^(W-1))^2 = 2^(2W-2)) is still positive in 2W signed bits.
    assign i_ext = {{IQ_WIDTH{i_in[IQ_WIDTH-1]}}, i_in};
    assign q_ext = {{IQ_WIDTH{q_in[IQ_WIDTH-1]}}, q_in};
    assign i_sq  = i_ext * i_ext;
    assign q_sq  = q_ext * q_ext;

    // Both squares are non-negative, so zero extension is exact and the
    // extra bit holds the carry of the sum.
    assign power_next = {1'b0, i_sq} + {1'b0, q_sq};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            power <= '0;
            ch    <= '0;
            valid <= 1'b0;
        end else begin
            power <= power_next;
            ch    <= ch_in;
            valid <= valid_in && !clear;
        end
    end

endmodule

// File: rtl/multichannel_power_detector.sv
// ----------------------------------------------------------------------------
// multichannel_power_detector
// Time-multiplexed average power detector. Each channel accumulates I^2+Q^2
// over a 2^win window; at window end the truncated average, channel tag,
// threshold flag and per-channel peak-hold are presented for one cycle.
//   clk, rst           clock, async active-high reset
//   i_in, q_in         signed IQ samples
//   ch_in              channel of the sample (>= NUM_CH is dropped)
//   sample_valid_in    sample qualifier
//   win_bits_cfg       window exponent, clamped to MAX_WIN_BITS
//   threshold_cfg      unsigned detection threshold
//   clear_in           synchronous clear of all channel state
//   avg_power_out      window average (saturated to OUT_WIDTH)
//   avg_ch_out         channel of avg_power_out
//   avg_power_valid    one-cycle strobe qualifying the avg_* outputs
//   above_thresh_out   avg_power_out > threshold_cfg
//   peak_hold_out      max average of avg_ch_out since clear/reset
// Pipeline: sample edge -> power (stage 1) -> accumulate/window end
// (stage 2) -> outputs and peak update (stage 3).
// ----------------------------------------------------------------------------
module multichannel_power_detector
    import power_det_pkg::*;
#(
    parameter int IQ_WIDTH     = DEF_IQ_WIDTH,
    parameter int NUM_CH       = 4,
    parameter int CH_BITS      = 2,
    parameter int MAX_WIN_BITS = DEF_MAX_WIN_BITS,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IQ_WIDTH-1:0]   i_in,
    input  logic [IQ_WIDTH-1:0]   q_in,
    input  logic [CH_BITS-1:0]    ch_in,
    input  logic                  sample_valid_in,
    input  logic [3:0]            win_bits_cfg,
    input  logic [OUT_WIDTH-1:0]  threshold_cfg,
    input  logic                  clear_in,
    output logic [OUT_WIDTH-1:0]  avg_power_out,
    output logic [CH_BITS-1:0]    avg_ch_out,
    output logic                  avg_power_valid,
    output logic                  above_thresh_out,
    output logic [OUT_WIDTH-1:0]  peak_hold_out
);

    localparam int ACC_WIDTH = acc_width(IQ_WIDTH, MAX_WIN_BITS);
    localparam int P_WIDTH   = 2 * IQ_WIDTH + 1;
    localparam int CNT_WIDTH = MAX_WIN_BITS;
    localparam logic [3:0]         WIN_MAX  = 4'(MAX_WIN_BITS);
    localparam logic [CH_BITS:0]   NUM_CH_L = (CH_BITS + 1)'(NUM_CH);

    // ---------------- stage 1: instantaneous power ----------------
    logic                  ch_ok;
    logic                  stage_valid_in;
    logic [3:0]            win_cfg_clamped;
    logic [P_WIDTH-1:0]    s1_power;
    logic [CH_BITS-1:0]    s1_ch;
    logic                  s1_valid;
    logic [3:0]            s1_win;

    assign ch_ok           = ({1'b0, ch_in} < NUM_CH_L);
    assign stage_valid_in  = sample_valid_in && ch_ok && !clear_in;
    assign win_cfg_clamped = (win_bits_cfg > WIN_MAX) ? WIN_MAX : win_bits_cfg;

    iq_power_stage #(
        .IQ_WIDTH (IQ_WIDTH),
        .CH_BITS  (CH_BITS)
    ) u_power (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_in),
        .i_in     (i_in),
        .q_in     (q_in),
        .ch_in    (ch_in),
        .valid_in (stage_valid_in),
        .power    (s1_power),
        .ch       (s1_ch),
        .valid    (s1_valid)
    );

    // The window size travels with the sample so that it reflects the
    // configuration at the time the sample was presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s1_win <= '0;
        else
            s1_win <= win_cfg_clamped;
    end

    // ---------------- stage 2: per-channel accumulation ----------------
    logic [ACC_WIDTH-1:0]  acc  [NUM_CH];
    logic [CNT_WIDTH-1:0]  cnt  [NUM_CH];
    logic [3:0]            win  [NUM_CH];
    logic [OUT_WIDTH-1:0]  peak [NUM_CH];

    logic [CNT_WIDTH-1:0]    cur_cnt;
    logic [3:0]              cur_win;
    logic [CNT_WIDTH:0]      term_cnt;
    logic                    win_end;
    logic [ACC_WIDTH-1:0]    acc_sum;
    logic [SAT_IN_WIDTH-1:0] sat_val;
    logic [OUT_WIDTH-1:0]    avg_next;

    always_comb begin
        cur_cnt  = cnt[s1_ch];
        // First sample of a window uses the freshly latched size.
        cur_win  = (cur_cnt == '0) ? s1_win : win[s1_ch];
        term_cnt = ((CNT_WIDTH + 1)'(1) << cur_win) - (CNT_WIDTH + 1)'(1);
        win_end  = s1_valid && ({1'b0, cur_cnt} == term_cnt);
        acc_sum  = acc[s1_ch] + ACC_WIDTH'(s1_power);
        sat_val  = sat_shift(SAT_IN_WIDTH'(acc_sum), cur_win, OUT_WIDTH);
        avg_next = sat_val[OUT_WIDTH-1:0];
    end

    // ---------------- stage 3: outputs and peak-hold ----------------
    logic                  end_valid;
    logic [CH_BITS-1:0]    end_ch;
    logic [OUT_WIDTH-1:0]  end_avg;
    logic [OUT_WIDTH-1:0]  peak_cur;
    logic [OUT_WIDTH-1:0]  peak_next;

    always_comb begin
        peak_cur  = peak[end_ch];
        peak_next = (end_avg > peak_cur) ? end_avg : peak_cur;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k]  <= '0;
                cnt[k]  <= '0;
                win[k]  <= '0;
                peak[k] <= '0;
            end
            end_valid        <= 1'b0;
            end_ch           <= '0;
            end_avg          <= '0;
            avg_power_out    <= '0;
            avg_ch_out       <= '0;
            avg_power_valid  <= 1'b0;
            above_thresh_out <= 1'b0;
            peak_hold_out    <= '0;
        end else if (clear_in) begin
            // Clear wins over everything in flight; outputs keep their
            // last values but no strobe is raised.
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k]  <= '0;
                cnt[k]  <= '0;
                peak[k] <= '0;
            end
            end_valid       <= 1'b0;
            avg_power_valid <= 1'b0;
        end else begin
            if (s1_valid) begin
                if (cur_cnt == '0)
                    win[s1_ch] <= cur_win;
                if (win_end) begin
                    acc[s1_ch] <= '0;
                    cnt[s1_ch] <= '0;
                end else begin
                    acc[s1_ch] <= acc_sum;
                    cnt[s1_ch] <= cur_cnt + CNT_WIDTH'(1);
                end
            end

            end_valid <= win_end;
            end_ch    <= s1_ch;
            end_avg   <= avg_next;

            avg_power_valid <= end_valid;
            if (end_valid) begin
                avg_power_out    <= end_avg;
                avg_ch_out       <= end_ch;
                above_thresh_out <= (end_avg > threshold_cfg);
                peak_hold_out    <= peak_next;
                peak[end_ch]     <= peak_next;
            end
        end
    end

endmodule

// File: tb/tb_multichannel_power_detector.sv
module tb_multichannel_power_detector;

    logic        clk;
    logic        rst;
    logic [15:0] i_in;
    logic [15:0] q_in;
    logic [1:0]  ch_in;
    logic        sample_valid_in;
    logic [3:0]  win_bits_cfg;
    logic [31:0] threshold_cfg;
    logic        clear_in;
    logic [31:0] avg_power_out;
    logic [1:0]  avg_ch_out;
    logic        avg_power_valid;
    logic        above_thresh_out;
    logic [31:0] peak_hold_out;

    multichannel_power_detector dut (
        .clk              (clk),
        .rst              (rst),
        .i_in             (i_in),
        .q_in             (q_in),
        .ch_in            (ch_in),
        .sample_valid_in  (sample_valid_in),
        .win_bits_cfg     (win_bits_cfg),
        .threshold_cfg    (threshold_cfg),
        .clear_in         (clear_in),
        .avg_power_out    (avg_power_out),
        .avg_ch_out       (avg_ch_out),
        .avg_power_valid  (avg_power_valid),
        .above_thresh_out (above_thresh_out),
        .peak_hold_out    (peak_hold_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] avg;
        logic        above;
        logic [31:0] peak;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Sample presented in the current cycle; capture happens at the next edge.
    task automatic send(input int ch, input int iv, input int qv, input bit clr = 1'b0);
        @(posedge clk); #1;
        ch_in           = ch[1:0];
        i_in            = iv[15:0];
        q_in            = qv[15:0];
        sample_valid_in = 1'b1;
        clear_in        = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sample_valid_in = 1'b0;
            clear_in        = 1'b0;
        end
    endtask

    // Called right after the send() of a window's last sample: strobe is due
    // three cycles later.
    task automatic expect_out(input int ch, input logic [31:0] avg, input logic above,
                              input logic [31:0] peak);
        exp_t x;
        x.ch    = ch[1:0];
        x.avg   = avg;
        x.above = above;
        x.peak  = peak;
        x.due   = cyc + 3;
        sb.push_back(x);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst && avg_power_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe ch=%0d avg=%0d cycle=%0d, required no strobe",
                         avg_ch_out, avg_power_out, cyc);
            end else begin
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.due);
                chk("avg_ch_out", avg_ch_out, e.ch);
                chk("avg_power_out", avg_power_out, e.avg);
                chk("above_thresh_out", above_thresh_out, e.above);
                chk("peak_hold_out", peak_hold_out, e.peak);
            end
        end
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog time limit reached, pending=%0d", sb.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        i_in            = '0;
        q_in            = '0;
        ch_in           = '0;
        sample_valid_in = 1'b0;
        clear_in        = 1'b0;
        win_bits_cfg    = 4'd2;
        threshold_cfg   = 32'd24;

        // Reset held with live samples: everything stays quiet
        repeat (5) begin
            send(0, 3, 4);
            @(negedge clk);
            chk("reset_quiet",
                avg_power_valid | above_thresh_out | (|avg_power_out) |
                (|avg_ch_out) | (|peak_hold_out), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        sample_valid_in = 1'b0;

        // Single channel, window 4, power 25
        for (int s = 0; s < 8; s++) begin
            send(0, 3, 4);
            if (s == 3 || s == 7) expect_out(0, 32'd25, 1'b1, 32'd25);
        end
        idle(6);

        // Interleaved ch0 (power 1) / ch1 (power 8), window 2
        win_bits_cfg  = 4'd1;
        threshold_cfg = 32'd5;
        for (int s = 0; s < 8; s++) begin
            if (s % 2 == 0) send(0, 1, 0);
            else            send(1, -2, -2);
            if (s == 2 || s == 6) expect_out(0, 32'd1, 1'b0, 32'd25);
            if (s == 3 || s == 7) expect_out(1, 32'd8, 1'b1, 32'd8);
        end
        idle(6);

        // Threshold / peak with window 1 on ch2
        win_bits_cfg  = 4'd0;
        threshold_cfg = 32'd100;
        send(2, 3, 4);  expect_out(2, 32'd25,  1'b0, 32'd25);
        send(2, 5, 12); expect_out(2, 32'd169, 1'b1, 32'd169);
        send(2, 3, 4);  expect_out(2, 32'd25,  1'b0, 32'd169);
        idle(6);
        @(posedge clk); #1;
        sample_valid_in = 1'b0;
        clear_in        = 1'b1;
        idle(1);
        send(2, 2, 0);  expect_out(2, 32'd4, 1'b0, 32'd4);
        idle(6);

        // Full scale; exponent 15 must clamp to 12 (4096 samples)
        win_bits_cfg = 4'd15;
        for (int s = 0; s < 4096; s++) begin
            send(3, -32768, -32768);
            if (s == 4095) expect_out(3, 32'h8000_0000, 1'b1, 32'h8000_0000);
        end
        idle(6);

        // Config change mid-window only affects the next window
        win_bits_cfg = 4'd2;
        send(0, 1, 1);
        send(0, 1, 1);
        win_bits_cfg = 4'd3;
        send(0, 1, 1);
        send(0, 1, 1);
        expect_out(0, 32'd2, 1'b0, 32'd2);
        for (int k = 1; k <= 8; k++) begin
            send(0, k, 0);          // sum of squares 204, /8 -> 25
            if (k == 8) expect_out(0, 32'd25, 1'b0, 32'd25);
        end
        idle(6);

        // Clear coincident with the 4th sample: no strobe, counting restarts
        win_bits_cfg = 4'd2;
        send(1, 2, 2);
        send(1, 2, 2);
        send(1, 2, 2);
        send(1, 2, 2, 1'b1);
        idle(3);
        for (int s = 0; s < 4; s++) begin
            send(1, 3, 4);
            if (s == 3) expect_out(1, 32'd25, 1'b0, 32'd25);
        end
        idle(6);

        // Clear while a window end is in flight: suppressed
        for (int s = 0; s < 4; s++) send(1, 3, 4);
        @(posedge clk); #1;
        sample_valid_in = 1'b0;
        clear_in        = 1'b1;
        idle(3);
        for (int s = 0; s < 4; s++) begin
            send(1, 5, 12);
            if (s == 3) expect_out(1, 32'd169, 1'b1, 32'd169);
        end
        idle(6);

        // Reset mid-window discards the partial sum
        send(2, 5, 12);
        send(2, 5, 12);
        @(posedge clk); #1;
        sample_valid_in = 1'b0;
        rst             = 1'b1;
        idle(2);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            send(2, 3, 4);
            if (s == 3) expect_out(2, 32'd25, 1'b0, 32'd25);
        end
        idle(8);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
